// File: rtl/hash_pkg.sv
// hash_pkg: constants and state encoding shared by hash_msg_packer and
// secure_hash_generator.
//   BLOCK_BYTES  bytes per packed block (block width = 8*BLOCK_BYTES)
//   PAD_BYTE     marker byte placed right after the last message byte
//   LEN_W        message byte-counter width (wraps modulo 2^LEN_W)
//   LEN_FIELD_W  width of the optional bit-length field at the block top
package hash_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam int unsigned LEN_W       = 32;
    localparam int unsigned LEN_FIELD_W = 32;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } pack_state_t;

endpackage

// File: rtl/hash_msg_packer.sv
// hash_msg_packer: packs a byte-serial message into BLOCK_BYTES-wide blocks,
// appends the PAD_BYTE marker plus zero fill, and flags the last block of
// each message.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   in_data/in_last valid
//   in_ready   packer accepts a byte this cycle (registered)
//   in_data    message byte
//   in_last    final byte of the message (only meaningful with in_valid)
//   blk_valid  blk_data/blk_final valid (registered)
//   blk_ready  downstream accepts the block
//   blk_data   packed block, byte k at [8k+7:8k], first byte at [7:0]
//   blk_final  block is the last block of its message
//
// Configuration
//   HASH_PACKER_LEN_APPEND_EN  when defined, the final block carries the
//   message bit length (count<<3, 32 bits, little-endian) in its top four
//   lanes; padding that would collide with that field spills into an extra
//   block.
module hash_msg_packer
    import hash_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = hash_pkg::BLOCK_BYTES,
    parameter logic [7:0]  PAD_BYTE    = hash_pkg::PAD_BYTE,
    parameter int unsigned LEN_W       = hash_pkg::LEN_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic [8*BLOCK_BYTES-1:0]   blk_data,
    output logic                       blk_final
);

    localparam int unsigned BW     = 8 * BLOCK_BYTES;
    localparam int unsigned IDX_W  = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);

    pack_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic [31:0]      idx_w;
    // a PADBLK block must follow the block currently in EMIT
    logic             go_pad;

    logic [BW-1:0]    lane_data;
    logic [BW-1:0]    pad_data;
    logic [BW-1:0]    pad_blk;

`ifdef HASH_PACKER_LEN_APPEND_EN
    // PAD_BYTE still owed to the extra block (it did not fit in the previous one)
    logic             pad_at0;
    logic [BW-1:0]    len_blk;
    logic             len_fits;

    function automatic logic [LEN_FIELD_W-1:0] bit_length(input logic [LEN_W-1:0] n);
        logic [LEN_W+2:0] ext;
        ext = {n, 3'b000};
        return ext[LEN_FIELD_W-1:0];
    endfunction
`endif

    assign count_inc = count + LEN_W'(1);
    assign idx_w     = 32'(idx);

    // lane_data: current block with the incoming byte written at lane idx.
    // pad_data : lane_data with PAD_BYTE at idx+1 and every higher lane zeroed.
    always_comb begin
        lane_data = blk_data;
        pad_data  = '0;
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if (k == idx_w) begin
                lane_data[8*k +: 8] = in_data;
            end
        end
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if (k <= idx_w) begin
                pad_data[8*k +: 8] = lane_data[8*k +: 8];
            end else if (k == idx_w + 32'd1) begin
                pad_data[8*k +: 8] = PAD_BYTE;
            end
        end
    end

`ifdef HASH_PACKER_LEN_APPEND_EN
    // The length field occupies the top four lanes, so the marker must land
    // at or below lane BLOCK_BYTES-5.
    assign len_fits = (idx_w + 32'd1) <= (BLOCK_BYTES - 32'd5);

    always_comb begin
        len_blk = pad_data;
        len_blk[BW-1 -: LEN_FIELD_W] = bit_length(count_inc);
    end

    always_comb begin
        pad_blk = '0;
        if (pad_at0) begin
            pad_blk[7:0] = PAD_BYTE;
        end
        pad_blk[BW-1 -: LEN_FIELD_W] = bit_length(count);
    end
`else
    always_comb begin
        pad_blk      = '0;
        pad_blk[7:0] = PAD_BYTE;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            count     <= '0;
            go_pad    <= 1'b0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_final <= 1'b0;
            blk_data  <= '0;
`ifdef HASH_PACKER_LEN_APPEND_EN
            pad_at0   <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        count <= count_inc;
                        if (in_last) begin
                            if (idx == IDX_LAST) begin
                                // block is full: marker goes into a follow-up block
                                blk_data  <= lane_data;
                                blk_final <= 1'b0;
                                go_pad    <= 1'b1;
`ifdef HASH_PACKER_LEN_APPEND_EN
                                pad_at0   <= 1'b1;
`endif
                            end else begin
`ifdef HASH_PACKER_LEN_APPEND_EN
                                if (len_fits) begin
                                    blk_data  <= len_blk;
                                    blk_final <= 1'b1;
                                    go_pad    <= 1'b0;
                                end else begin
                                    blk_data  <= pad_data;
                                    blk_final <= 1'b0;
                                    go_pad    <= 1'b1;
                                    pad_at0   <= 1'b0;
                                end
`else
                                blk_data  <= pad_data;
                                blk_final <= 1'b1;
                                go_pad    <= 1'b0;
`endif
                            end
                            blk_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= EMIT;
                        end else if (idx == IDX_LAST) begin
                            blk_data  <= lane_data;
                            blk_final <= 1'b0;
                            go_pad    <= 1'b0;
                            blk_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= EMIT;
                        end else begin
                            blk_data <= lane_data;
                            idx      <= idx + 1'b1;
                        end
                    end
                end

                EMIT: begin
                    in_ready <= 1'b0;
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_data  <= '0;
                        idx       <= '0;
                        if (go_pad) begin
                            state <= PADBLK;
                        end else begin
                            // in_ready comes back one cycle after the handshake
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            blk_final <= 1'b0;
                            if (blk_final) begin
                                count <= '0;
                            end
                        end
                    end
                end

                PADBLK: begin
                    blk_data  <= pad_blk;
                    blk_final <= 1'b1;
                    blk_valid <= 1'b1;
                    go_pad    <= 1'b0;
                    state     <= EMIT;
                end

                default: begin
                    state     <= FILL;
                    blk_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_packer.sv
// tb_hash_msg_packer: randomized and directed stimulus for hash_msg_packer,
// checked against a message-level padding model. Honors
// HASH_PACKER_LEN_APPEND_EN the same way as the design.
module tb_hash_msg_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         blk_final;

    int checks = 0;
    int errors = 0;

    logic [128:0] exp_q[$];   // {final, data} per expected block
    logic [7:0]   msg_q[$];   // message currently being sent
    logic [128:0] head;
    int           rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
    bit           mon_en = 1'b1;

    hash_msg_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_final (blk_final)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: message bytes, then the marker, then (optionally) a 4-byte
    // little-endian bit length at the very end, rounded up to whole blocks.
    task automatic push_expected();
        int n = msg_q.size();
        int used = n + 1;
        int nb;
        logic [7:0]   s[];
        logic [128:0] e;
        logic [31:0]  bl;
`ifdef HASH_PACKER_LEN_APPEND_EN
        used = used + 4;
`endif
        nb = (used + 15) / 16;
        s = new[nb * 16];
        foreach (s[i]) s[i] = 8'h00;
        for (int i = 0; i < n; i++) s[i] = msg_q[i];
        s[n] = 8'h80;
        bl = 32'(n) * 32'd8;
`ifdef HASH_PACKER_LEN_APPEND_EN
        for (int j = 0; j < 4; j++) s[nb*16 - 4 + j] = bl[8*j +: 8];
`endif
        for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int k = 0; k < 16; k++) e[8*k +: 8] = s[b*16 + k];
            e[128] = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    // blk_ready is updated just after each rising edge
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_ready = ($urandom_range(0, 3) != 0);
                1:       blk_ready = 1'b1;
                default: blk_ready = 1'b0;
            endcase
        end
    end

    // Every cycle a block is offered it must match the head of the model
    // queue (this also covers hold-stability while stalled).
    always @(negedge clk) begin
        if (!rst && mon_en && blk_valid) begin
            check("in_ready_low_in_emit", 128'(in_ready), 128'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_block", 128'd1, 128'd0);
            end else begin
                head = exp_q[0];
                check("blk_data", blk_data, head[127:0]);
                check("blk_final", 128'(blk_final), 128'(head[128]));
                if (blk_ready) head = exp_q.pop_front();
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte is taken.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input bit gaps);
        push_expected();
        for (int i = 0; i < msg_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
            send_byte(msg_q[i], i == msg_q.size() - 1);
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || !in_ready) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        int w;
        int lens[8] = '{11, 12, 13, 15, 16, 17, 27, 32};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_final", 128'(blk_final), 128'd0);
        check("rst_blk_data", blk_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_before_edge", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        check("in_ready_rise", 128'(in_ready), 128'd1);

        // 3-byte message; block appears on the edge that takes the last byte
        rdy_mode = 2;
        msg_q = '{8'hAA, 8'hBB, 8'hCC};
        send_msg(1'b0);
        check("latency_blk_valid", 128'(blk_valid), 128'd1);
        rdy_mode = 1;
        wait_drain();

        // full 16-byte message, then 12-byte message
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
        send_msg(1'b0);
        wait_drain();
        msg_q.delete();
        for (int i = 0; i < 12; i++) msg_q.push_back(8'(i));
        send_msg(1'b0);
        wait_drain();

        // two back-to-back 3-byte messages
        rand_msg(3);
        send_msg(1'b0);
        rand_msg(3);
        send_msg(1'b0);
        wait_drain();

        // stall a full block for 10 cycles, then release
        rdy_mode = 2;
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'(8'h20 + i));
        fork
            send_msg(1'b0);
            begin
                w = 0;
                while (!blk_valid && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check("stall_blk_valid_seen", 128'(blk_valid), 128'd1);
                repeat (10) begin
                    @(negedge clk);
                    check("stall_blk_valid", 128'(blk_valid), 128'd1);
                    check("stall_in_ready", 128'(in_ready), 128'd0);
                end
                rdy_mode = 1;
                @(negedge clk);
                check("hs_cycle", 128'(blk_valid && blk_ready), 128'd1);
                check("hs_cycle_in_ready", 128'(in_ready), 128'd0);
                @(negedge clk);
                check("in_ready_after_hs", 128'(in_ready), 128'd1);
            end
        join
        wait_drain();

        // reset after 7 accepted bytes
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_mid_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        check("rst_mid_hold_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(8'(8'h10 + i));
        send_msg(1'b0);
        wait_drain();

        // reset while a block is waiting in EMIT
        rdy_mode = 2;
        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        check("emit_before_rst", 128'(blk_valid), 128'd1);
        rst = 1'b1;
        #1;
        check("rst_emit_blk_valid", 128'(blk_valid), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rand_msg(5);
        send_msg(1'b0);
        wait_drain();

        // boundary lengths with random back-pressure
        rdy_mode = 0;
        foreach (lens[i]) begin
            rand_msg(lens[i]);
            send_msg(1'b1);
        end
        wait_drain();

        // random messages
        for (int m = 0; m < 30; m++) begin
            rand_msg($urandom_range(1, 40));
            send_msg(1'b1);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
